// File: rtl/vector_adder_pipe.sv
// vector_adder_pipe: two-stage, LANES-wide signed add/sub with wrap or saturate and valid/ready flow control
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_op operand side;
// out_valid/out_ready/out_result/out_ovf result side; op_count counts consumed results.
module vector_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [1:0]             in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [LANES-1:0]       out_ovf,
  output logic [CNT_W-1:0]       op_count
);
  localparam int W1 = WIDTH + 1;
  logic                        s1_valid;
  logic                        s1_adv;
  logic                        s2_adv;
  logic [1:0]                  s1_op;
  logic [LANES-1:0][WIDTH:0]   s1_raw;
  logic [LANES-1:0][WIDTH:0]   raw_d;
  logic [LANES-1:0][WIDTH-1:0] res_d;
  logic [LANES-1:0]            ovf_d;
  logic [WIDTH:0]              a_x;
  logic [WIDTH:0]              b_x;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  // One extra bit holds every signed sum/difference exactly; overflow is a
  // disagreement between the two top bits of that raw value.
  always_comb begin
    raw_d = '0;
    res_d = '0;
    ovf_d = '0;
    a_x   = '0;
    b_x   = '0;
    for (int i = 0; i < LANES; i++) begin
      a_x      = {in_a[i*WIDTH+WIDTH-1], in_a[i*WIDTH +: WIDTH]};
      b_x      = {in_b[i*WIDTH+WIDTH-1], in_b[i*WIDTH +: WIDTH]};
      raw_d[i] = a_x + (in_op[0] ? ~b_x : b_x) + W1'(in_op[0]);
      ovf_d[i] = s1_raw[i][WIDTH] ^ s1_raw[i][WIDTH-1];
      res_d[i] = (s1_op[1] && ovf_d[i]) ? {s1_raw[i][WIDTH], {(WIDTH-1){~s1_raw[i][WIDTH]}}}
                                        : s1_raw[i][WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_op    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_raw   <= raw_d;
      s1_op    <= in_op;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= '0;
      op_count   <= '0;
    end else begin
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        out_result <= res_d;
        out_ovf    <= ovf_d;
      end
      if (out_valid && out_ready) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_vector_adder_pipe.sv
// tb_vector_adder_pipe: table vectors, scoreboard stream, stall, reset and counter-wrap checks
module tb_vector_adder_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_ovf;
  logic [3:0]  op_count;
  logic [31:0] exp_r;
  logic [3:0]  exp_o;
  logic [3:0]  cnt_exp;
  logic [31:0] hold_r;
  logic [3:0]  hold_o;
  bit          hold_chk;
  bit          saw_stall;
  int          n_cmp;
  int          n_bad;
  logic [35:0] q[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] r;
    logic [3:0]  o;
  } vec_t;
  vec_t tbl[5];
  vector_adder_pipe #(.WIDTH(8), .LANES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf), .op_count(op_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [35:0] model(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic [31:0] r;
    logic [3:0]  o;
    int sa, sb, s;
    for (int i = 0; i < 4; i++) begin
      sa = $signed(a[i*8 +: 8]);
      sb = $signed(b[i*8 +: 8]);
      s  = op[0] ? sa - sb : sa + sb;
      o[i] = (s > 127) || (s < -128);
      r[i*8 +: 8] = (op[1] && s > 127) ? 8'h7F : (op[1] && s < -128) ? 8'h80 : s[7:0];
    end
    return {o, r};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt_exp  = '0;
      hold_chk = 1'b0;
    end else begin
      chk("op_count", op_count, cnt_exp);
      if (hold_chk) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", out_result, hold_r);
        chk("hold_ovf", out_ovf, hold_o);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", out_valid, 1'b0);
        else begin
          logic [35:0] e;
          e = q.pop_front();
          chk("result", out_result, e[31:0]);
          chk("ovf", out_ovf, e[35:32]);
        end
        cnt_exp = cnt_exp + 1'b1;
      end
      hold_chk = out_valid && !out_ready;
      hold_r   = out_result;
      hold_o   = out_ovf;
      if (in_valid && in_ready) q.push_back({exp_o, exp_r});
      if (in_valid && !in_ready) saw_stall = 1'b1;
    end
  end
  task automatic send(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [31:0] r, logic [3:0] o);
    int k;
    bit acc;
    k = 0;
    in_a = a; in_b = b; in_op = op; exp_r = r; exp_o = o; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 100);
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask
  task automatic send_rand();
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [35:0] e;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    e = model(a, b, op);
    send(a, b, op, e[31:0], e[35:32]);
  endtask
  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    tbl[0] = '{32'h7F01C864, 32'h01FF6432, 2'b00, 32'h80002C96, 4'b1001};
    tbl[1] = '{32'hFF3C807F, 32'hFF03FF01, 2'b10, 32'hFE3F807F, 4'b0011};
    tbl[2] = '{32'h05007F80, 32'h0580FF01, 2'b11, 32'h007F7F80, 4'b0111};
    tbl[3] = '{32'h32800A00, 32'h32010301, 2'b01, 32'h007F07FF, 4'b0100};
    tbl[4] = '{32'h0064E29C, 32'h001414CE, 2'b10, 32'h0078F680, 4'b0001};
    n_cmp = 0; n_bad = 0; saw_stall = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0; exp_r = '0; exp_o = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_op_count", op_count, 4'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_ovf", out_ovf, 4'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(tbl[0].a, tbl[0].b, tbl[0].op, tbl[0].r, tbl[0].o);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_1", out_valid, 1'b0);
    @(negedge clk);
    chk("latency_2", out_valid, 1'b1);
    drain();
    for (int i = 0; i < 5; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r, tbl[i].o);
    drain();
    do_reset();
    saw_stall = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    repeat (8) send_rand();
    drain();
    chk("stall_seen", saw_stall, 1'b1);
    chk("stream_count", op_count, 4'd8);
    do_reset();
    send_rand();
    send_rand();
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_op_count", op_count, 4'd0);
    chk("async_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_out", out_valid, 1'b0);
    do_reset();
    repeat (17) send_rand();
    drain();
    chk("count_wrap", op_count, 4'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vector_adder_pipe.md
VECTOR_ADDER_PIPE -- requirements
Module: vector_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 8, lane element width in bits (legal 2..32).
REQ-002 Parameter LANES, default 4, number of independent adder lanes (legal 1..16).
REQ-003 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand vector and op present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_a  input  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH].
REQ-009 in_b  input  LANES*WIDTH  operand B, same packing.
REQ-010 in_op  input  2  00 add-wrap, 01 sub-wrap, 10 add-sat-signed, 11 sub-sat-signed.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 out_result  output  LANES*WIDTH  per-lane result, same packing.
REQ-014 out_ovf  output  LANES  per-lane signed-overflow flag for the result.
REQ-015 op_count  output  CNT_W  number of results consumed since reset.

Function
REQ-016 Two-stage pipeline: S1 registers per-lane raw sum/difference at WIDTH+1 bits plus op; S2 registers saturated/wrapped result, flags, valid.
REQ-017 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Latency: accepted input appears on out_valid exactly 2 cycles later when out_ready held high.
REQ-019 Throughput: one operation per cycle with out_ready continuously high.
REQ-020 S2 advance = !s2_valid || out_ready; S1 advance = !s1_valid || S2 advance; in_ready = S1 advance (combinational, no dependence on in_valid).
REQ-021 Stalled stage holds its data, op and valid unchanged; no transfer is ever dropped or duplicated.
REQ-022 Sub computes a - b as a + ~b + 1 in WIDTH+1 bits, operands sign-extended.
REQ-023 out_ovf[i] = 1 when signed result of lane i is not representable in WIDTH bits, for all four ops.
REQ-024 Wrap ops: out_result lane = low WIDTH bits of raw result.
REQ-025 Sat ops: positive overflow -> 2^(WIDTH-1)-1, negative overflow -> -2^(WIDTH-1), else raw low bits.
REQ-026 Lanes fully independent; no carry between lanes.
REQ-027 out_result and out_ovf hold stable while out_valid && !out_ready.
REQ-028 op_count increments by 1 on each output transfer; wraps from 2^CNT_W-1 to 0.
REQ-029 Simultaneous input and output transfer in the same cycle with both stages full is legal and sustains full throughput.

Reset
REQ-030 rst_n low asynchronously clears s1_valid, s2_valid, out_valid, op_count to 0 and out_result, out_ovf to 0.
REQ-031 in_ready = 1 while rst_n low and in the first cycle after release.
REQ-032 Reset mid-operation discards all in-flight operations; no out_valid after release until a new input is accepted.

Verification
REQ-033 WIDTH=8, LANES=4, op=00, a lanes {100,200,1,127}, b {50,100,255,1} -> result {150,44,0,128}, ovf {1,0,0,1} on cycle 2.
REQ-034 op=10, a {127,-128,60,-1}, b {1,-1,3,-1} -> result {127,-128,63,-2}, ovf {1,1,0,0}.
REQ-035 op=11, a {-128,127,0,5}, b {1,-1,-128,5} -> result {-128,127,127,0}, ovf {1,1,1,0}.
REQ-036 Stream 8 back-to-back ops, out_ready low cycles 3-5 -> in_ready low after both stages fill, results in order, none lost, op_count=8.
REQ-037 Assert rst_n low while two ops in flight -> out_valid 0 immediately, op_count 0, no stale output after release.
REQ-038 CNT_W=4, 17 consumed results -> op_count wraps and reads 1.
